ltf_obf_scheduler: RTL and testbench
====================================

# ltf_obf_scheduler

Controller sitting between `dot11_tx` and the LTF generator. It owns the obfuscation coefficient tables, selects one 128-bit coefficient vector per packet, and launches the generator on `phy_tx_start`. It frames the 160-sample LTF stream with a valid window and a done pulse, and recovers the generator if it never starts.

## Interface
Parameters:
- `NUM_SLOTS`, default 4: number of 128-bit coefficient slots; power of 2, ≥2.
- `TIMEOUT`, default 256: maximum cycles in WAIT_START before recovery.
- `AW`, default `$clog2(NUM_SLOTS)+2`: config address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `phy_tx_start`  in  1  packet start request; single-cycle pulse.
- `cfg_we`  in  1  write strobe to the shadow table.
- `cfg_addr`  in  AW  `{slot, word}`; word 0 = bits [31:0] … word 3 = bits [127:96].
- `cfg_wdata`  in  32  write data.
- `cfg_commit`  in  1  pulse; copy shadow table to active table.
- `cfg_mode`  in  2  00 bypass, 01 fixed slot, 10 round-robin, 11 treated as bypass.
- `cfg_slot`  in  `log2(NUM_SLOTS)`  slot used in fixed mode.
- `err_clear`  in  1  clears sticky error flags.
- `gen_ltf_started`  in  1  generator first-sample flag.
- `gen_letsgo`  out  1  generator launch pulse.
- `gen_reset`  out  1  generator reset, used for recovery only.
- `gen_coefficients`  out  128  2 bits per carrier: 00 unchanged, 01 ÷8, 10 ÷2, 11 ÷4.
- `ltf_valid`  out  1  high exactly during the 160 LTF samples.
- `ltf_done`  out  1  one-cycle pulse after the last sample.
- `busy`  out  1  high in any state other than IDLE.
- `active_slot`  out  `log2(NUM_SLOTS)`  slot used for the current or last packet.
- `err_timeout`  out  1  sticky: generator never started.
- `err_overlap`  out  1  sticky: `phy_tx_start` arrived while busy.

## Operation
- **Tables.** Shadow and active tables each hold NUM_SLOTS×128 bits.
  - `cfg_we` writes the shadow table in any state.
  - Commit copies shadow → active and resets the round-robin pointer to 0.
  - A commit in IDLE takes effect at the next edge. A commit while busy is held pending and applied on the cycle the FSM enters IDLE.
- **Slot selection** happens at launch:
  - Bypass: coefficients are all zero and `active_slot` is unchanged.
  - Fixed: use `cfg_slot`.
  - Round-robin: use the pointer. The pointer increments modulo NUM_SLOTS on `ltf_done` only.
- **FSM:**
  - IDLE → ARM on `phy_tx_start`.
  - ARM (1 cycle): latch `gen_coefficients` and `active_slot`, drive `gen_letsgo`=1, clear the timeout counter → WAIT_START.
  - WAIT_START:
    - If `gen_ltf_started`=1: this is sample 1 and `ltf_valid`=1; sample counter := 1 → STREAM.
    - Otherwise increment the counter; when it reaches TIMEOUT → RECOVER.
  - STREAM: `ltf_valid`=1; count samples 2..160. On sample 160 → DONE.
  - DONE (1 cycle): `ltf_done`=1, advance the pointer if in round-robin → IDLE.
  - RECOVER (2 cycles): `gen_reset`=1, set `err_timeout` → IDLE. The pointer does not advance.
- `gen_coefficients` holds stable from ARM until the next ARM. It must not change while the generator is loading.
- `phy_tx_start` in any non-IDLE state is dropped and sets `err_overlap`.
- **Simultaneous events:**
  - `cfg_commit` together with `phy_tx_start` in IDLE: the commit is applied first, and the ARM that follows uses the new table.
  - `err_clear` together with a new error: the set wins.
- **Reset** (any state, including mid-stream): FSM → IDLE. Both tables, pointer, pending commit and counters are cleared to 0.

## Timing
- Reset values: every output is 0.
- `phy_tx_start` high at edge T:
  - `gen_letsgo` and new `gen_coefficients` are visible in cycle T+1.
  - `busy` is high from T+1.
- `ltf_valid` is combinational from `gen_ltf_started` in WAIT_START. It is registered state thereafter. It stays high for exactly 160 consecutive cycles.
- `ltf_done` is asserted in the cycle immediately after the last valid sample. `busy` drops in the cycle after `ltf_done`.
- Timeout:
  - Recovery starts when TIMEOUT cycles elapse after the `gen_letsgo` cycle without a start.
  - `gen_reset` is high for 2 cycles.
  - `err_timeout` is visible in the first RECOVER cycle + 1.
- Minimum packet-to-packet spacing: the next `phy_tx_start` is accepted in the first IDLE cycle.

## Test plan
- **Fixed mode:** write slot 1 = `0xAAAA…AAAA`, commit, mode 01, slot 1, pulse start → `gen_letsgo` at T+1 with coefficients `0xAAAA…`; after `gen_ltf_started`, `ltf_valid` is high for exactly 160 cycles, then a 1-cycle `ltf_done`.
- **Round-robin:** distinct patterns in slots 0–3, mode 10, four packets → `active_slot` sequence 0, 1, 2, 3; the fifth packet uses slot 0.
- **Deferred commit:** write the shadow table and pulse `cfg_commit` mid-STREAM → current `gen_coefficients` unchanged; the next packet uses the new values and round-robin restarts at 0.
- **Timeout:** hold `gen_ltf_started`=0 → RECOVER after 256 cycles, `gen_reset` high for 2 cycles, `err_timeout`=1, pointer unchanged; `err_clear` → 0.
- **Overlap:** start pulse during STREAM → ignored, `err_overlap`=1, sample count still 160.
- **Reset mid-stream:** assert `reset` at sample 80 → all outputs 0 next cycle, tables read back as zero in bypass-equivalent behaviour, and a new start launches with zero coefficients.

Source files
------------

// File: rtl/ltf_obf_scheduler.sv
// ltf_obf_scheduler: per-packet coefficient selection, LTF generator launch, valid/done framing and timeout recovery
module ltf_obf_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT = 256,
  parameter int AW = $clog2(NUM_SLOTS) + 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         phy_tx_start,
  input  logic                         cfg_we,
  input  logic [AW-1:0]                cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  input  logic                         cfg_commit,
  input  logic [1:0]                   cfg_mode,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic                         err_clear,
  input  logic                         gen_ltf_started,
  output logic                         gen_letsgo,
  output logic                         gen_reset,
  output logic [127:0]                 gen_coefficients,
  output logic                         ltf_valid,
  output logic                         ltf_done,
  output logic                         busy,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         err_timeout,
  output logic                         err_overlap
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2((TIMEOUT > 160 ? TIMEOUT : 160) + 1);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_START, STREAM, DONE, RECOVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_SLOTS-1:0][127:0] shadow, active, tbl;
  logic [SW-1:0] ptr, sel;
  logic pend, rr, do_commit, launch, use_tbl;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = phy_tx_start ? ARM : IDLE;
      ARM: begin
        state_n = WAIT_START;
        cnt_n = '0;
      end
      WAIT_START: begin
        if (gen_ltf_started) begin
          state_n = STREAM;
          cnt_n = CW'(1);
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = RECOVER;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
      STREAM: begin
        cnt_n = cnt + 1'b1;
        state_n = (cnt == CW'(159)) ? DONE : STREAM;
      end
      DONE: state_n = IDLE;
      RECOVER: begin
        cnt_n = CW'(1);
        state_n = (cnt != '0) ? IDLE : RECOVER;
      end
      default: state_n = IDLE;
    endcase
  end
  // a commit taking effect this cycle is forwarded so a simultaneous launch sees the new table and pointer
  assign do_commit = (state == IDLE) && (cfg_commit || pend);
  assign launch = (state == IDLE) && phy_tx_start;
  assign tbl = do_commit ? shadow : active;
  assign sel = (cfg_mode == 2'b01) ? cfg_slot : (do_commit ? '0 : ptr);
  assign use_tbl = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
  assign gen_letsgo = state == ARM;
  assign gen_reset = state == RECOVER;
  assign ltf_done = state == DONE;
  assign busy = state != IDLE;
  assign ltf_valid = (state == STREAM) || (state == WAIT_START && gen_ltf_started);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      active <= '0;
      ptr <= '0;
      pend <= 1'b0;
      rr <= 1'b0;
      gen_coefficients <= '0;
      active_slot <= '0;
      err_timeout <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (cfg_we) shadow[cfg_addr[SW+1:2]][{cfg_addr[1:0], 5'b0} +: 32] <= cfg_wdata;
      if (do_commit) active <= shadow;
      pend <= (state == IDLE) ? 1'b0 : (pend | cfg_commit);
      if (do_commit) ptr <= '0;
      else if (state == DONE && rr) ptr <= ptr + 1'b1;
      if (launch) begin
        rr <= cfg_mode == 2'b10;
        gen_coefficients <= use_tbl ? tbl[sel] : '0;
        if (use_tbl) active_slot <= sel;
      end
      err_timeout <= (state == RECOVER && cnt == '0) || (err_timeout && !err_clear);
      err_overlap <= (phy_tx_start && state != IDLE) || (err_overlap && !err_clear);
    end
  end
endmodule

// File: tb/tb_ltf_obf_scheduler.sv
// tb_ltf_obf_scheduler: directed packet table plus hand sequences for commit, timeout, overlap and reset
module tb_ltf_obf_scheduler;
  logic clk = 0, reset = 1, phy_tx_start = 0, cfg_we = 0, cfg_commit = 0, err_clear = 0, gen_ltf_started = 0;
  logic [3:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [1:0] cfg_mode = '0, cfg_slot = '0, active_slot;
  logic gen_letsgo, gen_reset, ltf_valid, ltf_done, busy, err_timeout, err_overlap;
  logic [127:0] gen_coefficients;
  int applied = 0, errors = 0;
  logic [127:0] p0 = {32{4'h1}}, p1 = {32{4'hA}}, p2 = {32{4'h5}}, p3 = {16{8'hC3}}, q = {16{8'h96}}, r = {16{8'h3E}};
  typedef struct {logic [1:0] mode; logic [1:0] slot; int delay; logic [1:0] eslot; logic [127:0] ecoef;} vec_t;
  vec_t vt[11];

  ltf_obf_scheduler dut (
    .clk(clk), .reset(reset), .phy_tx_start(phy_tx_start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_mode(cfg_mode), .cfg_slot(cfg_slot),
    .err_clear(err_clear), .gen_ltf_started(gen_ltf_started), .gen_letsgo(gen_letsgo), .gen_reset(gen_reset),
    .gen_coefficients(gen_coefficients), .ltf_valid(ltf_valid), .ltf_done(ltf_done), .busy(busy),
    .active_slot(active_slot), .err_timeout(err_timeout), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    applied++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic wr_slot(input logic [1:0] s, input logic [127:0] v);
    for (int w = 0; w < 4; w++) begin
      cfg_we = 1;
      cfg_addr = {s, 2'(w)};
      cfg_wdata = v[w*32 +: 32];
      step();
    end
    cfg_we = 0;
  endtask

  // act: 0 none, 1 commit at sample `at`, 2 start at sample `at`, 3 reset at sample `at`, 4 commit with start
  task automatic run_pkt(input logic [1:0] mode, input logic [1:0] slot, input int delay, input logic [1:0] eslot,
                         input logic [127:0] ecoef, input int act, input int at);
    int n;
    cfg_mode = mode;
    cfg_slot = slot;
    cfg_commit = (act == 4);
    phy_tx_start = 1;
    step();
    phy_tx_start = 0;
    cfg_commit = 0;
    chk("letsgo", 128'(gen_letsgo), 1);
    chk("coef", gen_coefficients, ecoef);
    chk("slot", 128'(active_slot), 128'(eslot));
    chk("busy", 128'(busy), 1);
    step();
    chk("letsgo_pulse", 128'(gen_letsgo), 0);
    repeat (delay) begin
      chk("early_valid", 128'(ltf_valid), 0);
      step();
    end
    gen_ltf_started = 1;
    #1;
    chk("valid_comb", 128'(ltf_valid), 1);
    n = 1;
    step();
    gen_ltf_started = 0;
    for (int i = 0; i < 400 && ltf_valid; i++) begin
      n++;
      if (n == at) begin
        cfg_commit = (act == 1);
        phy_tx_start = (act == 2);
        reset = (act == 3);
      end
      step();
      cfg_commit = 0;
      phy_tx_start = 0;
      if (act == 3 && n == at) begin
        reset = 0;
        chk("post_reset_ctl", 128'({gen_letsgo, gen_reset, ltf_valid, ltf_done, busy, active_slot, err_timeout, err_overlap}), 0);
        chk("post_reset_coef", gen_coefficients, 0);
        return;
      end
    end
    chk("valid_count", 128'(n), 160);
    chk("done", 128'(ltf_done), 1);
    chk("coef_hold", gen_coefficients, ecoef);
    step();
    chk("done_pulse", 128'(ltf_done), 0);
    chk("idle", 128'(busy), 0);
  endtask

  initial begin
    int w;
    vt[0]  = '{2'b01, 2'd1, 0, 2'd1, p1};
    vt[1]  = '{2'b10, 2'd3, 3, 2'd0, p0};
    vt[2]  = '{2'b10, 2'd0, 1, 2'd1, p1};
    vt[3]  = '{2'b10, 2'd0, 0, 2'd2, p2};
    vt[4]  = '{2'b10, 2'd0, 2, 2'd3, p3};
    vt[5]  = '{2'b10, 2'd2, 0, 2'd0, p0};
    vt[6]  = '{2'b00, 2'd3, 1, 2'd0, '0};
    vt[7]  = '{2'b11, 2'd2, 0, 2'd0, '0};
    vt[8]  = '{2'b01, 2'd3, 4, 2'd3, p3};
    vt[9]  = '{2'b10, 2'd0, 0, 2'd1, p1};
    vt[10] = '{2'b00, 2'd2, 0, 2'd1, '0};
    repeat (3) step();
    reset = 0;
    chk("reset_ctl", 128'({gen_letsgo, gen_reset, ltf_valid, ltf_done, busy, active_slot, err_timeout, err_overlap}), 0);
    chk("reset_coef", gen_coefficients, 0);
    wr_slot(2'd0, p0);
    wr_slot(2'd1, p1);
    wr_slot(2'd2, p2);
    wr_slot(2'd3, p3);
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    for (int i = 0; i < 11; i++) run_pkt(vt[i].mode, vt[i].slot, vt[i].delay, vt[i].eslot, vt[i].ecoef, 0, 0);
    // deferred commit mid-stream; pointer is at 2 here
    wr_slot(2'd0, q);
    run_pkt(2'b10, 2'd0, 2, 2'd2, p2, 1, 50);
    run_pkt(2'b10, 2'd0, 0, 2'd0, q, 0, 0);
    // timeout with pointer at 1
    cfg_mode = 2'b10;
    phy_tx_start = 1;
    step();
    phy_tx_start = 0;
    chk("to_letsgo", 128'(gen_letsgo), 1);
    chk("to_slot", 128'(active_slot), 1);
    step();
    w = 0;
    while (!gen_reset && w < 400) begin
      w++;
      step();
    end
    chk("to_wait_cycles", 128'(w), 256);
    chk("to_rst1", 128'(gen_reset), 1);
    chk("to_err_early", 128'(err_timeout), 0);
    step();
    chk("to_rst2", 128'(gen_reset), 1);
    chk("to_err", 128'(err_timeout), 1);
    step();
    chk("to_rst_end", 128'(gen_reset), 0);
    chk("to_idle", 128'(busy), 0);
    chk("to_err_sticky", 128'(err_timeout), 1);
    err_clear = 1;
    step();
    err_clear = 0;
    chk("to_err_clear", 128'(err_timeout), 0);
    run_pkt(2'b10, 2'd0, 0, 2'd1, p1, 0, 0);
    // overlap during stream
    run_pkt(2'b01, 2'd3, 1, 2'd3, p3, 2, 40);
    chk("overlap_err", 128'(err_overlap), 1);
    err_clear = 1;
    step();
    err_clear = 0;
    chk("overlap_clear", 128'(err_overlap), 0);
    // commit together with start in idle
    wr_slot(2'd2, r);
    run_pkt(2'b01, 2'd2, 0, 2'd2, r, 4, 0);
    // reset at sample 80, then tables are empty
    run_pkt(2'b01, 2'd1, 1, 2'd1, p1, 3, 80);
    run_pkt(2'b01, 2'd1, 0, 2'd1, '0, 0, 0);
    run_pkt(2'b10, 2'd0, 0, 2'd0, '0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
